cdb_result_queue: RTL and testbench

CDB_RESULT_QUEUE -- requirements
Module: cdb_result_queue

---
 rtl/cdb_result_queue.sv | 92 +++++++++
 tb/tb_cdb_result_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_result_queue.sv
// ALU result queue feeding the common data bus.
// Show-ahead FIFO of {rob tag, value}; flush and rst empty it.
`ifndef Reg_Lock_Width
`define Reg_Lock_Width 6
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock 6'd0
`endif

module cdb_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [`Reg_Lock_Width-1:0]   in_index,
  input  logic [`Data_Width-1:0]       in_data,
  input  logic                         flush,
  output logic                         cdb_req,
  input  logic                         cdb_grnt,
  output logic [`Reg_Lock_Width-1:0]   cdb_index,
  output logic [`Data_Width-1:0]       cdb_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [`Reg_Lock_Width-1:0] NOLOCK = `Reg_No_Lock;

  logic [`Reg_Lock_Width-1:0] idx_mem [DEPTH];
  logic [`Data_Width-1:0]     dat_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready = (count_q < FULL);
  assign cdb_req  = (count_q != '0);
  assign count    = count_q;

  // Storage is never visible while empty, so it carries no reset.
  assign cdb_index = cdb_req ? idx_mem[head_q] : NOLOCK;
  assign cdb_data  = cdb_req ? dat_mem[head_q] : '0;

  always_comb begin
    push    = in_valid && in_ready && !flush
              && (in_index != NOLOCK);
    pop     = cdb_req && cdb_grnt && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail_q] <= in_index;
      dat_mem[tail_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Bench for cdb_result_queue: directed scenarios plus random traffic
// checked by a queue-based scoreboard sampled on the falling edge.
`ifndef Reg_Lock_Width
`define Reg_Lock_Width 6
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock 6'd0
`endif

module tb_cdb_result_queue;

  localparam int DEPTH = 4;
  localparam int IW = `Reg_Lock_Width;
  localparam int DW = `Data_Width;
  localparam logic [IW-1:0] NOLOCK = `Reg_No_Lock;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_index;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          cdb_req;
  logic          cdb_grnt;
  logic [IW-1:0] cdb_index;
  logic [DW-1:0] cdb_data;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;

  logic [IW+DW-1:0] sb[$];

  cdb_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_data(in_data),
    .flush(flush),
    .cdb_req(cdb_req), .cdb_grnt(cdb_grnt),
    .cdb_index(cdb_index), .cdb_data(cdb_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected entries enter at accepted pushes, leave at grants.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
    end else if (flush) begin
      sb.delete();
    end else begin
      automatic bit do_pop  = (sb.size() != 0) && cdb_grnt;
      automatic bit do_push = in_valid && (sb.size() < DEPTH)
                              && (in_index != NOLOCK);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({in_index, in_data});
    end
  end

  always @(negedge clk) begin
    chk("mon_count", 64'(count), 64'(sb.size()));
    chk("mon_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    chk("mon_req", 64'(cdb_req), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("mon_index", 64'(cdb_index), 64'(sb[0][IW+DW-1:DW]));
      chk("mon_data", 64'(cdb_data), 64'(sb[0][DW-1:0]));
    end else begin
      chk("mon_idle_index", 64'(cdb_index), 64'(NOLOCK));
      chk("mon_idle_data", 64'(cdb_data), 64'd0);
    end
  end

  // Apply inputs for one cycle; returns 1ns after the edge.
  task automatic cyc(input logic v, input logic [IW-1:0] idx,
                     input logic [DW-1:0] d, input logic g,
                     input logic f);
    in_valid = v;
    in_index = idx;
    in_data  = d;
    cdb_grnt = g;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic g);
    cyc(1'b0, NOLOCK, '0, g, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_index = NOLOCK;
    in_data = '0;
    flush = 1'b0;
    cdb_grnt = 1'b0;
    #2;
    chk("rst_req", 64'(cdb_req), 64'd0);
    chk("rst_index", 64'(cdb_index), 64'(NOLOCK));
    chk("rst_data", 64'(cdb_data), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b0);

    // Single result with grant held.
    cyc(1'b1, 6'd3, 32'h0000_00AA, 1'b1, 1'b0);
    chk("single_req", 64'(cdb_req), 64'd1);
    chk("single_idx", 64'(cdb_index), 64'd3);
    chk("single_data", 64'(cdb_data), 64'hAA);
    idle(1'b1);
    chk("single_after_req", 64'(cdb_req), 64'd0);
    chk("single_after_idx", 64'(cdb_index), 64'(NOLOCK));

    // Fill while the bus is withheld; the fifth push is dropped.
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, IW'(i), DW'(32'h100 + i), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_idx", 64'(cdb_index), 64'(i));
      idle(1'b1);
    end
    chk("drain_empty", 64'(cdb_req), 64'd0);

    // Push and pop together, then keep going across the wrap.
    for (int i = 1; i <= 3; i++)
      cyc(1'b1, IW'(i), DW'(32'h200 + i), 1'b0, 1'b0);
    cyc(1'b1, 6'd9, 32'h209, 1'b1, 1'b0);
    chk("pp_count", 64'(count), 64'd3);
    chk("pp_head", 64'(cdb_index), 64'd2);
    for (int i = 10; i <= 13; i++)
      cyc(1'b1, IW'(i), DW'(32'h200 + i), 1'b1, 1'b0);
    chk("wrap_count", 64'(count), 64'd3);
    chk("wrap_head", 64'(cdb_index), 64'd11);
    for (int i = 11; i <= 13; i++) begin
      chk("wrap_order", 64'(cdb_index), 64'(i));
      idle(1'b1);
    end

    // Flush beats a concurrent push and pop.
    cyc(1'b1, 6'd4, 32'h44, 1'b0, 1'b0);
    cyc(1'b1, 6'd5, 32'h55, 1'b0, 1'b0);
    cyc(1'b1, 6'd6, 32'h66, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_req", 64'(cdb_req), 64'd0);
    idle(1'b0);
    chk("flush_absent", 64'(count), 64'd0);

    // Asynchronous reset between edges.
    for (int i = 1; i <= 3; i++)
      cyc(1'b1, IW'(20 + i), DW'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_req", 64'(cdb_req), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 6'd7, 32'h77, 1'b0, 1'b0);
    chk("arst_push_head", 64'(cdb_index), 64'd7);
    chk("arst_push_count", 64'(count), 64'd1);
    idle(1'b1);

    // Ignored inputs.
    cyc(1'b1, NOLOCK, 32'hDEAD, 1'b0, 1'b0);
    chk("nolock_count", 64'(count), 64'd0);
    idle(1'b1);
    chk("grnt_empty_count", 64'(count), 64'd0);
    chk("grnt_empty_idx", 64'(cdb_index), 64'(NOLOCK));

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      automatic logic [IW-1:0] ri = IW'($urandom_range(0, 15));
      cyc(1'(($urandom_range(0, 3)) != 0), ri, DW'($urandom),
          1'(($urandom_range(0, 2)) == 0),
          1'(($urandom_range(0, 40)) == 0));
    end

    idle(1'b1);
    idle(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
